// File: rtl/bmp_stream_pkg.sv
// Types and constants shared by the BMP frame reader and the BMP image writer.
// States: IDLE wait for start | VSYNC frame marker | ACTIVE row reads | HBLANK row gap | DRAIN flush buffer
package bmp_stream_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_VSYNC  = 3'd1;
    localparam state_t ST_ACTIVE = 3'd2;
    localparam state_t ST_HBLANK = 3'd3;
    localparam state_t ST_DRAIN  = 3'd4;

    // Field order matches the memory word, so a word casts directly to a pair.
    typedef struct packed {
        logic [7:0] r1;
        logic [7:0] g1;
        logic [7:0] b1;
        logic [7:0] r0;
        logic [7:0] g0;
        logic [7:0] b0;
    } pix_pair_t;

    localparam int B0_LSB = 0;
    localparam int G0_LSB = 8;
    localparam int R0_LSB = 16;
    localparam int B1_LSB = 24;
    localparam int G1_LSB = 32;
    localparam int R1_LSB = 40;

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry fall-through valid/ready buffer: an arriving word is presented in
// the same cycle when the buffer is empty, and is stored only if not taken.
module pixel_skid_buf #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   free_cnt
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign out_valid = (count != 2'd0) || in_valid;
    assign push      = in_valid && !((count == 2'd0) && out_ready);
    assign pop       = (count != 2'd0) && out_ready;
    assign free_cnt  = 2'd2 - count;

    // Data is forced to zero when nothing is presented so idle outputs read 0.
    always_comb begin
        out_data = '0;
        if (count != 2'd0)
            out_data = slot[rd_ptr];
        else if (in_valid)
            out_data = in_data;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= in_data;
                wr_ptr       <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/bmp_frame_reader.sv
// Replays a bottom-up 24-bit BMP pixel array top-down as two-pixel beats
// with vsync framing, row blanking and valid/ready backpressure.
module bmp_frame_reader
    import bmp_stream_pkg::*;
#(
    parameter int Im_width  = 768,
    parameter int Im_height = 512,
    parameter int VSYNC_CYC = 4,
    parameter int HBLANK    = 8,
    parameter int AW        = 18
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [47:0]   mem_rdata,
    input  logic          out_ready,
    output logic          vsync,
    output logic          hsync,
    output logic [7:0]    R0_out,
    output logic [7:0]    G0_out,
    output logic [7:0]    B0_out,
    output logic [7:0]    R1_out,
    output logic [7:0]    G1_out,
    output logic [7:0]    B1_out,
    output logic          Read_Done
);

    localparam logic [AW-1:0] PAIRS   = AW'(Im_width / 2);
    localparam logic [AW-1:0] PAIRS_M1 = AW'(Im_width / 2 - 1);
    localparam logic [AW-1:0] ROWS_M1 = AW'(Im_height - 1);
    localparam logic [AW-1:0] TOTAL   = AW'(Im_width * Im_height / 2);
    localparam logic [AW-1:0] ONE     = AW'(1);

    state_t        state;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] row_base;
    logic [AW-1:0] beat_cnt;
    logic [7:0]    timer;
    logic          rd_q;
    logic [1:0]    free_cnt;
    logic          buf_valid;
    logic [47:0]   buf_data;
    logic          issue;
    logic          accept;
    logic          drained;

    // A read already in flight occupies a slot before its data lands.
    assign issue   = (state == ST_ACTIVE) && (free_cnt > {1'b0, rd_q});
    assign accept  = buf_valid && out_ready;
    assign drained = (state == ST_DRAIN) && !rd_q && (free_cnt == 2'd2) && (beat_cnt == TOTAL);

    assign mem_rd    = issue;
    assign mem_addr  = issue ? row_base + col : '0;
    assign vsync     = (state == ST_VSYNC);
    assign hsync     = buf_valid;
    assign Read_Done = drained;

    assign B0_out = buf_data[B0_LSB +: 8];
    assign G0_out = buf_data[G0_LSB +: 8];
    assign R0_out = buf_data[R0_LSB +: 8];
    assign B1_out = buf_data[B1_LSB +: 8];
    assign G1_out = buf_data[G1_LSB +: 8];
    assign R1_out = buf_data[R1_LSB +: 8];

    pixel_skid_buf #(.W(48)) u_skid (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (rd_q),
        .in_data   (mem_rdata),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (buf_data),
        .free_cnt  (free_cnt)
    );

    // row_base trails row by one cycle; VSYNC and HBLANK cover that lag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            beat_cnt <= '0;
            timer    <= '0;
            rd_q     <= 1'b0;
        end else begin
            rd_q     <= issue;
            row_base <= (ROWS_M1 - row) * PAIRS;
            if (accept)
                beat_cnt <= beat_cnt + ONE;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_VSYNC;
                        timer    <= 8'(VSYNC_CYC - 1);
                        row      <= '0;
                        col      <= '0;
                        beat_cnt <= '0;
                    end
                end
                ST_VSYNC: begin
                    if (timer == 8'd0)
                        state <= ST_ACTIVE;
                    else
                        timer <= timer - 8'd1;
                end
                ST_ACTIVE: begin
                    if (issue) begin
                        if (col == PAIRS_M1) begin
                            col <= '0;
                            row <= row + ONE;
                            if (row == ROWS_M1) begin
                                state <= ST_DRAIN;
                            end else begin
                                state <= ST_HBLANK;
                                timer <= 8'(HBLANK - 1);
                            end
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (timer == 8'd0)
                        state <= ST_ACTIVE;
                    else
                        timer <= timer - 8'd1;
                end
                ST_DRAIN: begin
                    if (drained)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_frame_reader.sv
// Directed bench: a 4x2 reader for timing and byte order, a 16x4 reader for
// backpressure, random ready and mid-frame reset.
module tb_bmp_frame_reader;
    import bmp_stream_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: 4x2 ----------------
    logic        start_a, rd_a, ready_a, vs_a, hs_a, done_a;
    logic [17:0] addr_a;
    logic [47:0] rdata_a = '0;
    logic [7:0]  r0_a, g0_a, b0_a, r1_a, g1_a, b1_a;
    logic [47:0] pix_a;
    assign pix_a = {r1_a, g1_a, b1_a, r0_a, g0_a, b0_a};

    bmp_frame_reader #(.Im_width(4), .Im_height(2), .VSYNC_CYC(4), .HBLANK(8), .AW(18)) dut_a (
        .clk(clk), .Reset(Reset), .start(start_a), .mem_addr(addr_a), .mem_rd(rd_a),
        .mem_rdata(rdata_a), .out_ready(ready_a), .vsync(vs_a), .hsync(hs_a),
        .R0_out(r0_a), .G0_out(g0_a), .B0_out(b0_a), .R1_out(r1_a), .G1_out(g1_a), .B1_out(b1_a),
        .Read_Done(done_a));

    always @(posedge clk) if (rd_a) rdata_a <= 48'hA1B2C3_D4E5F4 + 48'(addr_a);

    // ---------------- DUT B: 16x4 ----------------
    logic        start_b, rd_b, ready_b, vs_b, hs_b, done_b;
    logic [7:0]  addr_b;
    logic [47:0] rdata_b = '0;
    logic [7:0]  r0_b, g0_b, b0_b, r1_b, g1_b, b1_b;
    logic [47:0] pix_b;
    assign pix_b = {r1_b, g1_b, b1_b, r0_b, g0_b, b0_b};

    bmp_frame_reader #(.Im_width(16), .Im_height(4), .VSYNC_CYC(4), .HBLANK(8), .AW(8)) dut_b (
        .clk(clk), .Reset(Reset), .start(start_b), .mem_addr(addr_b), .mem_rd(rd_b),
        .mem_rdata(rdata_b), .out_ready(ready_b), .vsync(vs_b), .hsync(hs_b),
        .R0_out(r0_b), .G0_out(g0_b), .B0_out(b0_b), .R1_out(r1_b), .G1_out(g1_b), .B1_out(b1_b),
        .Read_Done(done_b));

    function automatic logic [47:0] word_b(input int a);
        logic [7:0] x;
        x = 8'(a);
        return {x ^ 8'h50, x ^ 8'h40, x ^ 8'h30, x ^ 8'h20, x ^ 8'h10, x};
    endfunction

    always @(posedge clk) if (rd_b) rdata_b <= word_b(int'(addr_b));

    // ---------------- monitors ----------------
    logic [47:0] beats_a[$];
    int rd_addr_a[$], rd_cyc_a[$], beat_cyc_a[$];
    int done_cnt_a = 0, vs_cnt_a = 0, vs_last_a = 0;

    always @(negedge clk) if (!Reset) begin
        if (rd_a) begin rd_addr_a.push_back(int'(addr_a)); rd_cyc_a.push_back(cyc); end
        if (hs_a && ready_a) begin beats_a.push_back(pix_a); beat_cyc_a.push_back(cyc); end
        if (done_a) done_cnt_a++;
        if (vs_a) begin vs_cnt_a++; vs_last_a = cyc; end
    end

    logic [47:0] beats_b[$];
    int rd_addr_b[$];
    int done_cnt_b = 0, issued_b = 0, accepted_b = 0, max_out_b = 0, unstable_b = 0;
    logic stall_prev = 1'b0;
    logic [47:0] pix_prev = '0;

    always @(negedge clk) begin
        if (Reset) begin
            issued_b = 0; accepted_b = 0; stall_prev = 1'b0;
        end else begin
            if (rd_b) begin rd_addr_b.push_back(int'(addr_b)); issued_b++; end
            if (hs_b && ready_b) begin beats_b.push_back(pix_b); accepted_b++; end
            if (issued_b - accepted_b > max_out_b) max_out_b = issued_b - accepted_b;
            if (done_b) done_cnt_b++;
            if (stall_prev && (!hs_b || pix_b !== pix_prev)) unstable_b++;
            stall_prev = hs_b && !ready_b;
            pix_prev   = pix_b;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit sel_b, input int target, input int budget, input string tag);
        int n;
        n = 0;
        while ((sel_b ? done_cnt_b : done_cnt_a) < target && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_done_in_time"}, 64'((sel_b ? done_cnt_b : done_cnt_a) >= target), 64'd1);
    endtask

    // Beats of a 16x4 frame must arrive top row first: addr = (3-r)*8 + c.
    task automatic check_seq(input string tag);
        int mism, r, c;
        mism = 0;
        for (int k = 0; k < 32; k++) begin
            r = k / 8;
            c = k % 8;
            if (k >= beats_b.size() || beats_b[k] !== word_b((3 - r) * 8 + c)) mism++;
        end
        check({tag, "_beat_count"}, 64'(beats_b.size()), 64'd32);
        check({tag, "_sequence_mismatches"}, 64'(mism), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    int exp_addr_a[4] = '{2, 3, 0, 1};
    int n, base_done, base_vs, base_beats, base_rd;
    pix_pair_t p;

    initial begin
        Reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        tick(3);
        Reset = 1'b0;
        tick(1);
        check("rst_vsync", 64'(vs_a), 64'd0);
        check("rst_hsync", 64'(hs_a), 64'd0);
        check("rst_mem_rd", 64'(rd_a), 64'd0);
        check("rst_mem_addr", 64'(addr_a), 64'd0);
        check("rst_read_done", 64'(done_a), 64'd0);
        check("rst_pixels", 64'(pix_a), 64'd0);

        // nominal 4x2 frame
        start_a = 1'b1; tick(1); start_a = 1'b0;
        wait_done(1'b0, 1, 100, "nom");
        tick(3);
        check("nom_vsync_cycles", 64'(vs_cnt_a), 64'd4);
        check("nom_read_count", 64'(rd_addr_a.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("nom_read_addr", 64'((rd_addr_a.size() > i) ? rd_addr_a[i] : -1), 64'(exp_addr_a[i]));
        check("nom_vsync_to_first_read", 64'((rd_cyc_a.size() > 0) ? rd_cyc_a[0] - vs_last_a : -1), 64'd1);
        check("nom_hblank_gap", 64'((rd_cyc_a.size() > 2) ? rd_cyc_a[2] - rd_cyc_a[1] : -1), 64'd9);
        check("nom_first_beat_latency",
              64'((rd_cyc_a.size() > 0 && beat_cyc_a.size() > 0) ? beat_cyc_a[0] - rd_cyc_a[0] : -1), 64'd1);
        check("nom_beat_count", 64'(beats_a.size()), 64'd4);
        check("nom_read_done_count", 64'(done_cnt_a), 64'd1);
        for (int i = 0; i < 4; i++)
            check("nom_beat_data", (beats_a.size() > i) ? 64'(beats_a[i]) : 64'hDEAD,
                  64'(48'hA1B2C3_D4E5F4 + 48'(exp_addr_a[i])));

        // byte order on the word 48'hA1B2C3_D4E5F6 (addr 2, first beat)
        p = (beats_a.size() > 0) ? pix_pair_t'(beats_a[0]) : pix_pair_t'(48'h0);
        check("byte_b0", 64'(p.b0), 64'hF6);
        check("byte_g0", 64'(p.g0), 64'hE5);
        check("byte_r0", 64'(p.r0), 64'hD4);
        check("byte_b1", 64'(p.b1), 64'hC3);
        check("byte_g1", 64'(p.g1), 64'hB2);
        check("byte_r1", 64'(p.r1), 64'hA1);

        // start pulses during VSYNC, ACTIVE and coincident with Read_Done
        base_done = done_cnt_a; base_vs = vs_cnt_a; base_beats = beats_a.size(); base_rd = rd_addr_a.size();
        start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(2);
        start_a = 1'b1; tick(1); start_a = 1'b0;
        start_a = 1'b1; tick(1); start_a = 1'b0;
        n = 0;
        while (!done_a && n < 100) begin @(negedge clk); n++; end
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        tick(30);
        check("busy_read_done_count", 64'(done_cnt_a - base_done), 64'd1);
        check("busy_vsync_cycles", 64'(vs_cnt_a - base_vs), 64'd4);
        check("busy_beat_count", 64'(beats_a.size() - base_beats), 64'd4);
        check("busy_read_count", 64'(rd_addr_a.size() - base_rd), 64'd4);

        // backpressure mid-row on the 16x4 reader
        start_b = 1'b1; tick(1); start_b = 1'b0;
        tick(7);
        max_out_b = 0;
        ready_b = 1'b0;
        tick(10);
        check("bp_max_outstanding", 64'(max_out_b), 64'd2);
        ready_b = 1'b1;
        wait_done(1'b1, 1, 300, "bp");
        tick(2);
        check_seq("bp");
        check("bp_read_done_count", 64'(done_cnt_b), 64'd1);
        check("bp_outputs_stable", 64'(unstable_b), 64'd0);

        // random out_ready over a whole frame
        beats_b.delete();
        base_done = done_cnt_b;
        max_out_b = 0;
        start_b = 1'b1; tick(1); start_b = 1'b0;
        n = 0;
        while (done_cnt_b < base_done + 1 && n < 2000) begin
            ready_b = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        ready_b = 1'b1;
        tick(2);
        check("rnd_read_done_count", 64'(done_cnt_b - base_done), 64'd1);
        check_seq("rnd");
        check("rnd_outputs_stable", 64'(unstable_b), 64'd0);
        check("rnd_outstanding_le2", 64'(max_out_b <= 2), 64'd1);

        // reset held 3 cycles mid-ACTIVE
        base_done = done_cnt_b;
        start_b = 1'b1; tick(1); start_b = 1'b0;
        tick(6);
        Reset = 1'b1;
        tick(3);
        check("midrst_mem_rd", 64'(rd_b), 64'd0);
        check("midrst_mem_addr", 64'(addr_b), 64'd0);
        check("midrst_vsync", 64'(vs_b), 64'd0);
        check("midrst_hsync", 64'(hs_b), 64'd0);
        check("midrst_pixels", 64'(pix_b), 64'd0);
        check("midrst_read_done", 64'(done_b), 64'd0);
        Reset = 1'b0;
        tick(40);
        check("midrst_no_read_done", 64'(done_cnt_b - base_done), 64'd0);
        rd_addr_b.delete();
        beats_b.delete();
        start_b = 1'b1; tick(1); start_b = 1'b0;
        wait_done(1'b1, base_done + 1, 300, "postrst");
        tick(2);
        check("postrst_first_addr", 64'((rd_addr_b.size() > 0) ? rd_addr_b[0] : -1), 64'd24);
        check_seq("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
